// File: rtl/miniaig_sweep_pkg.sv
// Purpose: shared types, MISR constants and golden-table lookup for the MiniAig equivalence sweeper.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package miniaig_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Golden tables are passed zero-extended to a fixed width so one helper serves every N_PI/N_PO.
    localparam int GOLD_IDX_W = 12;
    localparam int GOLD_MAX   = 1 << GOLD_IDX_W;

    // Expected value of output `po` for input vector `idx`: tbl[po * 2^n_pi + idx].
    function automatic logic golden_bit(input logic [GOLD_MAX-1:0] tbl,
                                        input int unsigned        n_pi,
                                        input int unsigned        po,
                                        input int unsigned        idx);
        int unsigned pos;
        pos = po * (32'd1 << n_pi) + idx;
        return tbl[pos[GOLD_IDX_W-1:0]];
    endfunction

endpackage

// File: rtl/miniaig_sweep_delay.sv
// Purpose: valid+index shift pipeline that tracks which vector the netlist output currently reflects.
// Latency: DUT_LAT cycles (combinational pass-through when DUT_LAT = 0).
// Backpressure: none; advances every cycle.
module miniaig_sweep_delay #(
    parameter int N_PI    = 5,
    parameter int DUT_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [N_PI-1:0] in_idx,
    output logic            out_vld,
    output logic [N_PI-1:0] out_idx
);

    localparam int EW = N_PI + 1;
    localparam int PW = (DUT_LAT > 0 ? DUT_LAT : 1) * EW;

    generate
        if (DUT_LAT == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_vld = in_vld;
            assign out_idx = in_idx;
        end else begin : g_pipe
            // Entry layout: {vld, idx}; newest entry in the low bits, oldest in the high bits.
            logic [PW-1:0] pipe_q;

            if (DUT_LAT == 1) begin : g_one
                // Single stage: capture the issued entry each cycle.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_q <= '0;
                    end else begin
                        pipe_q <= {in_vld, in_idx};
                    end
                end
            end else begin : g_many
                // Multi-stage: shift toward the high end, inserting the issued entry at the bottom.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_q <= '0;
                    end else begin
                        pipe_q <= {pipe_q[PW-EW-1:0], in_vld, in_idx};
                    end
                end
            end

            assign out_vld = pipe_q[PW-1];
            assign out_idx = pipe_q[PW-2 -: N_PI];
        end
    endgenerate

endmodule

// File: rtl/miniaig_equiv_sweeper.sv
// Purpose: exhaustive PI stimulus + PO compare against a golden truth table; MISR signature under MINIAIG_SWEEP_MISR_EN.
// Latency: done rises 2^N_PI + DUT_LAT + 1 cycles after an accepted start.
// Backpressure: none; start is ignored while busy, the netlist is assumed to accept a vector every cycle.
module miniaig_equiv_sweeper
    import miniaig_sweep_pkg::*;
#(
    parameter int                        N_PI    = 5,
    parameter int                        N_PO    = 1,
    parameter int                        DUT_LAT = 0,
    parameter logic [N_PO*(2**N_PI)-1:0] GOLDEN  = 32'hF888_F888
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_PI:0]   mismatch_cnt,
    output logic [N_PI-1:0] first_fail_idx,
    output logic [N_PI-1:0] pi_o,
    input  logic [N_PO-1:0] po_i,
    output logic [15:0]     sig
);

    localparam logic [N_PI-1:0]     IDX_MAX    = '1;
    localparam logic [N_PI:0]       CNT_MAX    = {1'b1, {N_PI{1'b0}}};
    localparam logic [GOLD_MAX-1:0] GOLD_EXT   = GOLD_MAX'(GOLDEN);
    localparam int                  DRAIN_W    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    sweep_state_t       state_q, state_d;
    logic               accept;
    logic               last_issued_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic               iss_vld_q;
    logic               del_vld;
    logic [N_PI-1:0]    del_idx;
    logic [N_PO-1:0]    exp_po;
    logic               cmp_fail;
    logic               enter_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RUN spends one extra cycle after the last vector is issued so the final
    // compare lands before DONE; DRAIN then covers the netlist's register stages.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (last_issued_q) begin
                    state_d = (DUT_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state_q != DONE) && (state_d == DONE);

    // Vector issue: pi_o walks 0..2^N_PI-1 once, then holds; iss_vld_q tags each fresh vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pi_o          <= '0;
            iss_vld_q     <= 1'b0;
            last_issued_q <= 1'b0;
        end else if (accept) begin
            pi_o          <= '0;
            iss_vld_q     <= 1'b1;
            last_issued_q <= 1'b0;
        end else if (state_q == RUN && !last_issued_q) begin
            if (pi_o == IDX_MAX) begin
                iss_vld_q     <= 1'b0;
                last_issued_q <= 1'b1;
            end else begin
                pi_o      <= pi_o + 1'b1;
                iss_vld_q <= 1'b1;
            end
        end else begin
            iss_vld_q <= 1'b0;
        end
    end

    // Drain counter: counts cycles spent in DRAIN, cleared everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_q <= '0;
        end else if (state_q == DRAIN) begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
        end else begin
            drain_cnt_q <= '0;
        end
    end

    miniaig_sweep_delay #(
        .N_PI    (N_PI),
        .DUT_LAT (DUT_LAT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (iss_vld_q),
        .in_idx  (pi_o),
        .out_vld (del_vld),
        .out_idx (del_idx)
    );

    // Golden PO vector for the index the netlist output currently corresponds to.
    always_comb begin
        exp_po = '0;
        for (int j = 0; j < N_PO; j++) begin
            exp_po[j] = golden_bit(GOLD_EXT, N_PI, j, 32'(del_idx));
        end
    end

    assign cmp_fail = del_vld && (po_i != exp_po);

    // Result accumulation: one compare per valid pipeline slot; pass latched on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
        end else if (accept) begin
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
        end else begin
            if (cmp_fail) begin
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (mismatch_cnt == '0) begin
                    first_fail_idx <= del_idx;
                end
            end
            if (enter_done) begin
                pass <= (mismatch_cnt == '0);
            end
        end
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == RUN) || (state_d == DRAIN);
            done <= (state_d == DONE);
        end
    end

`ifdef MINIAIG_SWEEP_MISR_EN
    // Response signature: CRC-style MISR folded with the PO bus on every valid compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= '0;
        end else if (accept) begin
            sig <= MISR_SEED;
        end else if (del_vld) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ 16'(po_i);
        end
    end
`else
    assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_miniaig_equiv_sweeper.sv
// Purpose: self-checking bench for miniaig_equiv_sweeper (DUT_LAT=0 and DUT_LAT=2 instances) with a netlist fault model.
// Latency: checks done at start+33 (DUT_LAT=0) and start+35 (DUT_LAT=2).
// Backpressure: exercises ignored start pulses while busy.
`timescale 1ns/1ps
module tb_miniaig_equiv_sweeper;

    localparam int NV = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [5:0]  cnt_a, cnt_b;
    logic [4:0]  ffi_a, ffi_b, pi_a, pi_b;
    logic [15:0] sig_a, sig_b;
    logic [0:0]  po_a, po_b;
    logic        po_comb_a, reg_po_a2, po_b_q;
    logic [4:0]  reg_pi_a1, reg_pi_b1;

    int          fault_mode;
    logic [31:0] flip_mask;
    logic        use_reg;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Reference function of the netlist: po0 = (pi0&pi1)|(pi2&pi3).
    function automatic logic golden_f(input int i);
        logic [4:0] v;
        v = i[4:0];
        return (v[0] & v[1]) | (v[2] & v[3]);
    endfunction

    // Netlist under test: mode 0 = golden xor flip mask, 1 = stuck-at-0, 2 = stuck-at-1.
    function automatic logic net_f(input int mode, input logic [31:0] flip, input int i);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return golden_f(i) ^ flip[i[4:0]];
        endcase
    endfunction

    function automatic int model_cnt(input int mode, input logic [31:0] flip);
        int c;
        c = 0;
        for (int i = 0; i < NV; i++) if (net_f(mode, flip, i) != golden_f(i)) c++;
        return c;
    endfunction

    function automatic int model_first(input int mode, input logic [31:0] flip);
        for (int i = 0; i < NV; i++) if (net_f(mode, flip, i) != golden_f(i)) return i;
        return 0;
    endfunction

    function automatic logic [15:0] model_sig(input int mode, input logic [31:0] flip);
        logic [15:0] s;
`ifdef MINIAIG_SWEEP_MISR_EN
        s = 16'hFFFF;
        for (int i = 0; i < NV; i++)
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, net_f(mode, flip, i)};
`else
        s = 16'h0000;
        if (mode < 0 && flip != 0) s = 16'h0001;
`endif
        return s;
    endfunction

    // Netlist models: combinational and 2-stage registered copies.
    assign po_comb_a = net_f(fault_mode, flip_mask, int'(pi_a));
    always_ff @(posedge clk) begin
        reg_pi_a1 <= pi_a;
        reg_po_a2 <= net_f(fault_mode, flip_mask, int'(reg_pi_a1));
        reg_pi_b1 <= pi_b;
        po_b_q    <= net_f(fault_mode, flip_mask, int'(reg_pi_b1));
    end
    assign po_a[0] = use_reg ? reg_po_a2 : po_comb_a;
    assign po_b[0] = po_b_q;

    miniaig_equiv_sweeper #(.N_PI(5), .N_PO(1), .DUT_LAT(0), .GOLDEN(32'hF888_F888)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .mismatch_cnt(cnt_a), .first_fail_idx(ffi_a), .pi_o(pi_a), .po_i(po_a), .sig(sig_a));

    miniaig_equiv_sweeper #(.N_PI(5), .N_PO(1), .DUT_LAT(2), .GOLDEN(32'hF888_F888)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .mismatch_cnt(cnt_b), .first_fail_idx(ffi_b), .pi_o(pi_b), .po_i(po_b), .sig(sig_b));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Starts a sweep on instance inst, optionally pulsing start while busy; returns the cycle
    // offset (edges after the start edge) at which done is first seen, or -1 on timeout.
    task automatic run_sweep(input int inst, input bit storm, output int cyc, output int pi_bad);
        logic d, b;
        logic [4:0] p;
        @(negedge clk);
        if (inst == 1) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = -1;
        pi_bad = 0;
        for (int k = 0; k < 200; k++) begin
            d = (inst == 1) ? done_b : done_a;
            b = (inst == 1) ? busy_b : busy_a;
            p = (inst == 1) ? pi_b : pi_a;
            if (k < NV && int'(p) != k) pi_bad++;
            if (d) begin
                cyc = k;
                break;
            end
            if (storm && b && $urandom_range(0, 3) == 0) begin
                if (inst == 1) start_b = 1'b1; else start_a = 1'b1;
            end
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    typedef struct {
        int          inst;
        int          mode;
        logic [31:0] flip;
        bit          use_reg;
        bit          storm;
        int          exp_cyc;
        int          exp_cnt;    // -1: only "greater than zero" is required
        int          exp_first;  // -1: not checked
        int          exp_pass;
        bit          chk_sig;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cyc, pi_bad, got_cnt, got_first, got_pass, got_busy, got_sig, inst, kind, waited;
        logic [31:0] fm;

        tbl[0] = '{0, 0, 32'h0,         1'b0, 1'b1, 33,  0,  0, 1, 1'b1};
        tbl[1] = '{0, 1, 32'h0,         1'b0, 1'b0, 33, 14,  3, 0, 1'b1};
        tbl[2] = '{0, 2, 32'h0,         1'b0, 1'b1, 33, 18,  0, 0, 1'b1};
        tbl[3] = '{1, 0, 32'h0,         1'b0, 1'b1, 35,  0,  0, 1, 1'b1};
        tbl[4] = '{0, 0, 32'h0,         1'b1, 1'b0, 33, -1, -1, 0, 1'b0};
        tbl[5] = '{0, 0, 32'h0,         1'b0, 1'b0, 33,  0,  0, 1, 1'b1};
        tbl[6] = '{0, 0, 32'h8000_0001, 1'b0, 1'b0, 33,  2,  0, 0, 1'b1};
        tbl[7] = '{1, 0, 32'h0000_0400, 1'b0, 1'b1, 35,  1, 10, 0, 1'b1};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        fault_mode = 0; flip_mask = '0; use_reg = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",  int'(busy_a), 0);
        check("reset_done",  int'(done_a), 0);
        check("reset_pass",  int'(pass_a), 0);
        check("reset_cnt",   int'(cnt_a),  0);
        check("reset_first", int'(ffi_a),  0);
        check("reset_pi",    int'(pi_a),   0);
        check("reset_sig",   int'(sig_a),  0);
        rst = 1'b0;

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            fault_mode = tbl[v].mode;
            flip_mask  = tbl[v].flip;
            use_reg    = tbl[v].use_reg;
            run_sweep(tbl[v].inst, tbl[v].storm, cyc, pi_bad);
            got_cnt   = (tbl[v].inst == 1) ? int'(cnt_b)  : int'(cnt_a);
            got_first = (tbl[v].inst == 1) ? int'(ffi_b)  : int'(ffi_a);
            got_pass  = (tbl[v].inst == 1) ? int'(pass_b) : int'(pass_a);
            got_busy  = (tbl[v].inst == 1) ? int'(busy_b) : int'(busy_a);
            got_sig   = (tbl[v].inst == 1) ? int'(sig_b)  : int'(sig_a);
            check($sformatf("vec%0d_done_cycle", v), cyc, tbl[v].exp_cyc);
            check($sformatf("vec%0d_pi_seq_errs", v), pi_bad, 0);
            check($sformatf("vec%0d_busy_at_done", v), got_busy, 0);
            check($sformatf("vec%0d_pass", v), got_pass, tbl[v].exp_pass);
            if (tbl[v].exp_cnt < 0) check($sformatf("vec%0d_cnt_nonzero", v), int'(got_cnt > 0), 1);
            else                    check($sformatf("vec%0d_cnt", v), got_cnt, tbl[v].exp_cnt);
            if (tbl[v].exp_first >= 0) check($sformatf("vec%0d_first", v), got_first, tbl[v].exp_first);
            if (tbl[v].chk_sig) check($sformatf("vec%0d_sig", v), got_sig, int'(model_sig(tbl[v].mode, tbl[v].flip)));
        end
        use_reg = 1'b0;

        // Reset in the middle of a failing sweep, at vector 10.
        fault_mode = 2; flip_mask = '0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        waited = 0;
        while (pi_a != 5'd10 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("midrst_reached_vec10", int'(pi_a), 10);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",  int'(busy_a), 0);
        check("midrst_done",  int'(done_a), 0);
        check("midrst_pass",  int'(pass_a), 0);
        check("midrst_cnt",   int'(cnt_a),  0);
        check("midrst_first", int'(ffi_a),  0);
        check("midrst_pi",    int'(pi_a),   0);
        check("midrst_sig",   int'(sig_a),  0);
        rst = 1'b0;
        fault_mode = 0;
        run_sweep(0, 1'b0, cyc, pi_bad);
        check("post_rst_done_cycle", cyc, 33);
        check("post_rst_pass", int'(pass_a), 1);
        check("post_rst_cnt", int'(cnt_a), 0);

        // Randomized fault masks on either instance against the reference model.
        for (int r = 0; r < 16; r++) begin
            inst = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            if (kind == 0)      fm = '0;
            else if (kind == 1) fm = 32'd1 << $urandom_range(0, 31);
            else                fm = $urandom() & $urandom();
            fault_mode = 0;
            flip_mask  = fm;
            run_sweep(inst, 1'b1, cyc, pi_bad);
            got_cnt   = (inst == 1) ? int'(cnt_b)  : int'(cnt_a);
            got_first = (inst == 1) ? int'(ffi_b)  : int'(ffi_a);
            got_pass  = (inst == 1) ? int'(pass_b) : int'(pass_a);
            got_sig   = (inst == 1) ? int'(sig_b)  : int'(sig_a);
            check($sformatf("rnd%0d_done_cycle", r), cyc, (inst == 1) ? 35 : 33);
            check($sformatf("rnd%0d_pi_seq_errs", r), pi_bad, 0);
            check($sformatf("rnd%0d_cnt", r), got_cnt, model_cnt(0, fm));
            check($sformatf("rnd%0d_first", r), got_first, model_first(0, fm));
            check($sformatf("rnd%0d_pass", r), got_pass, int'(fm == 32'h0));
            check($sformatf("rnd%0d_sig", r), got_sig, int'(model_sig(0, fm)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/miniaig_equiv_sweeper.md
Name: miniaig_equiv_sweeper

Overview:
- Upstream stimulus driver and downstream response checker for one ABC-generated MiniAig netlist.
- Drives the netlist PI bus exhaustively through all 2^N_PI input vectors, consumes its PO bus, and compares each PO vector against a golden truth table.
- Reports mismatch count, first failing vector index, pass/fail, and optionally a response signature.
- Used to confirm that a resynthesized netlist is equivalent to the original, one DUT per sweeper.

Parameters:
- N_PI, 5, number of primary inputs driven; vector index range 0..2^N_PI-1.
- N_PO, 1, number of primary outputs checked.
- DUT_LAT, 0, register stages between pi_o and po_i (0 = purely combinational netlist).
- GOLDEN, 32'hF888_F888, truth tables, N_PO*2^N_PI bits; PO j expected value for vector i = GOLDEN[j*2^N_PI + i]. The default is po0 = (pi0&pi1)|(pi2&pi3).

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until the next accepted start or rst.
- pass  out  1  valid while done=1; 1 iff mismatch_cnt==0.
- mismatch_cnt  out  N_PI+1  number of vectors on which any PO differed from GOLDEN.
- first_fail_idx  out  N_PI  index of the first mismatching vector; 0 if none.
- pi_o  out  N_PI  registered vector driven to the netlist PIs.
- po_i  in  N_PO  netlist POs.
- sig  out  16  response signature; see Optional Feature.

Behaviour:
- Every output is driven from a register.
- Reset, any state, including mid-sweep: state=IDLE; busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, pi_o=0, sig=0; index pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE / DONE + start:
  - go to RUN;
  - clear mismatch_cnt, first_fail_idx, pass, done;
  - pi_o=0; push valid index 0 into the pipeline.
- RUN:
  - each cycle pi_o increments by 1;
  - (valid, index) is pushed into a DUT_LAT-deep shift pipeline in step with pi_o;
  - when pi_o == 2^N_PI-1 has been issued, go to DRAIN (DUT_LAT>0) or to DONE on the following cycle (DUT_LAT=0).
- DRAIN:
  - lasts exactly DUT_LAT cycles; pi_o holds its last value and pushes invalid entries;
  - then go to DONE.
- Compare:
  - on each cycle where the pipeline output is valid, compare po_i against the GOLDEN bits for the delayed index;
  - on any bit difference, increment mismatch_cnt;
  - if this is the first mismatch, load first_fail_idx with the delayed index.
- Exactly 2^N_PI compares per sweep. mismatch_cnt saturates at 2^N_PI, which is reached only if every vector fails.
- Timing: start sampled at cycle t; done rises at cycle t+2^N_PI+DUT_LAT+1; pass updates in the same cycle.
- start while busy is ignored, with no effect on state or counters.
- start in the same cycle as rst: rst wins.
- Index wrap: pi_o never wraps within a sweep; it restarts at 0 only on a new start.

Optional Feature:
- Macro: MINIAIG_SWEEP_MISR_EN.
- Defined:
  - sig is a 16-bit MISR, seeded 16'hFFFF on an accepted start;
  - on each valid compare cycle, sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended po_i;
  - the final value is held in DONE.
- Undefined: sig is constant 0 and no MISR logic is built.

Decomposition:
- Package miniaig_sweep_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - MISR_POLY=16'h1021 and MISR_SEED=16'hFFFF;
  - a function giving the golden bit for a (po, index) pair.
- One natural sub-module: miniaig_sweep_delay, the DUT_LAT-deep valid+index shift pipeline, which degenerates to a wire when DUT_LAT=0.

Test Plan:
- Correct DUT, defaults, start at t: done at t+33; pass=1; mismatch_cnt=0; first_fail_idx=0. pi_o runs 0..31 on consecutive cycles.
- po stuck-at-0: mismatch_cnt=14 (popcount of F888F888), first_fail_idx=3, pass=0.
- po stuck-at-1: mismatch_cnt=18, first_fail_idx=0, pass=0.
- DUT_LAT=2 with a 2-stage registered correct DUT: done at t+35, pass=1. The same DUT with DUT_LAT=0 fails, with mismatch_cnt>0.
- Robustness: rst asserted at vector 10 forces all outputs to their reset values in the next cycle. start pulses during RUN are ignored. A fresh start after DONE gives the same results as the first sweep.
- With MINIAIG_SWEEP_MISR_EN: sig on the correct DUT equals the bench-computed MISR of F888F888 from seed FFFF; a stuck-at fault yields a different sig. Without the macro, sig stays 0.
